// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_pkg
// Shared EX-stage definitions for the iterative divider: FSM state encoding,
// iteration count, special-case result constants and a magnitude helper.
// -----------------------------------------------------------------------------
package seq_divider_pkg;

   localparam int DIV_WIDTH  = 32;
   localparam int DIV_CYCLES = 32;
   localparam int CNT_W      = $clog2(DIV_CYCLES);

   localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
   localparam logic [DIV_WIDTH-1:0] INT_MIN       = 32'h8000_0000;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_FIX  = 2'd2,
      DIV_DONE = 2'd3
   } div_state_e;

   // Absolute value of a two's-complement operand; unsigned operands pass
   // through untouched so 0xFFFFFFFF stays a large positive number.
   function automatic logic [DIV_WIDTH-1:0] magnitude(input logic [DIV_WIDTH-1:0] x,
                                                      input logic             is_signed);
      return (is_signed && x[DIV_WIDTH-1]) ? -x : x;
   endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// -----------------------------------------------------------------------------
// seq_divider_div_step
// One restoring-division step: trial subtract of the divisor magnitude from the
// shifted partial remainder.
//   rem_shift_i   [WIDTH:0]   partial remainder shifted left with next dividend bit
//   divisor_mag_i [WIDTH-1:0] divisor magnitude
//   next_rem_o    [WIDTH-1:0] partial remainder after this step
//   q_bit_o                   quotient bit produced by this step
// -----------------------------------------------------------------------------
module seq_divider_div_step
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH:0]   rem_shift_i,
   input  logic [WIDTH-1:0] divisor_mag_i,
   output logic [WIDTH-1:0] next_rem_o,
   output logic             q_bit_o
);

   logic [WIDTH:0] diff;

   // The partial remainder is always below the divisor, so the difference
   // never exceeds WIDTH bits and bit WIDTH is a reliable borrow/sign flag.
   assign diff       = rem_shift_i - {1'b0, divisor_mag_i};
   assign q_bit_o    = ~diff[WIDTH];
   assign next_rem_o = q_bit_o ? diff[WIDTH-1:0] : rem_shift_i[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Iterative restoring divider, one quotient bit per clock, signed or unsigned,
// with a start/busy/valid handshake for pipeline stalling.
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset
//   start_i          request, accepted only when idle
//   signed_i         1 = two's-complement divide (sampled with start_i)
//   opr0_i / opr1_i  dividend / divisor (sampled with start_i)
//   busy_o           high whenever an operation is in flight
//   valid_o          one-cycle result strobe
//   quotient_o       quotient, held until the next accepted start
//   remainder_o      remainder, held until the next accepted start
//   div_zero_flag_o  divisor was zero
//   overflow_flag_o  signed INT_MIN / -1
// -----------------------------------------------------------------------------
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             signed_i,
   input  logic [WIDTH-1:0] opr0_i,
   input  logic [WIDTH-1:0] opr1_i,
   output logic             busy_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             div_zero_flag_o,
   output logic             overflow_flag_o
);

   div_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] dvd_mag_q;
   logic [WIDTH-1:0] dvs_mag_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic             neg_quo_q;   // operand signs differed (signed only)
   logic             neg_rem_q;   // dividend was negative (signed only)

   logic [WIDTH:0]   rem_shift_d;
   logic [WIDTH-1:0] rem_d;
   logic             q_bit_d;

   // Dividend bits are consumed MSB first, indexed by the down-counter.
   assign rem_shift_d = {rem_q, dvd_mag_q[cnt_q]};

   seq_divider_div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_shift_i   (rem_shift_d),
      .divisor_mag_i (dvs_mag_q),
      .next_rem_o    (rem_d),
      .q_bit_o       (q_bit_d)
   );

   // NOTE: every register here is assigned with <= so all updates read the
   // pre-edge values; a blocking = would let later statements see new values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q         <= DIV_IDLE;
         cnt_q           <= '0;
         dvd_mag_q       <= '0;
         dvs_mag_q       <= '0;
         rem_q           <= '0;
         quo_q           <= '0;
         neg_quo_q       <= 1'b0;
         neg_rem_q       <= 1'b0;
         busy_o          <= 1'b0;
         valid_o         <= 1'b0;
         quotient_o      <= '0;
         remainder_o     <= '0;
         div_zero_flag_o <= 1'b0;
         overflow_flag_o <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         case (state_q)
            DIV_IDLE: begin
               if (start_i) begin
                  dvd_mag_q <= magnitude(opr0_i, signed_i);
                  dvs_mag_q <= magnitude(opr1_i, signed_i);
                  neg_quo_q <= signed_i & (opr0_i[WIDTH-1] ^ opr1_i[WIDTH-1]);
                  neg_rem_q <= signed_i & opr0_i[WIDTH-1];
                  rem_q     <= '0;
                  quo_q     <= '0;
                  cnt_q     <= CNT_W'(DIV_CYCLES - 1);
                  busy_o    <= 1'b1;
                  if (opr1_i == '0) begin
                     // Divide by zero: all-ones quotient, dividend passes through.
                     quotient_o      <= DIV_ZERO_QUOT;
                     remainder_o     <= opr0_i;
                     div_zero_flag_o <= 1'b1;
                     overflow_flag_o <= 1'b0;
                     valid_o         <= 1'b1;
                     state_q         <= DIV_DONE;
                  end else if (signed_i && opr0_i == INT_MIN && opr1_i == '1) begin
                     // -2^31 / -1 is unrepresentable; wrap to INT_MIN.
                     quotient_o      <= INT_MIN;
                     remainder_o     <= '0;
                     div_zero_flag_o <= 1'b0;
                     overflow_flag_o <= 1'b1;
                     valid_o         <= 1'b1;
                     state_q         <= DIV_DONE;
                  end else begin
                     div_zero_flag_o <= 1'b0;
                     overflow_flag_o <= 1'b0;
                     state_q         <= DIV_CALC;
                  end
               end
            end
            DIV_CALC: begin
               rem_q <= rem_d;
               quo_q <= {quo_q[WIDTH-2:0], q_bit_d};
               if (cnt_q == '0) state_q <= DIV_FIX;
               else             cnt_q   <= cnt_q - 1'b1;
            end
            DIV_FIX: begin
               // Truncating division: remainder follows the dividend's sign.
               quotient_o  <= neg_quo_q ? -quo_q : quo_q;
               remainder_o <= neg_rem_q ? -rem_q : rem_q;
               valid_o     <= 1'b1;
               state_q     <= DIV_DONE;
            end
            DIV_DONE: begin
               busy_o  <= 1'b0;
               state_q <= DIV_IDLE;
            end
            default: begin
               busy_o  <= 1'b0;
               state_q <= DIV_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Directed-vector bench for seq_divider with hand-computed expected results.
// -----------------------------------------------------------------------------
module tb_seq_divider;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        signed_i;
   logic [31:0] opr0_i;
   logic [31:0] opr1_i;
   logic        busy_o;
   logic        valid_o;
   logic [31:0] quotient_o;
   logic [31:0] remainder_o;
   logic        div_zero_flag_o;
   logic        overflow_flag_o;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   seq_divider dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .start_i         (start_i),
      .signed_i        (signed_i),
      .opr0_i          (opr0_i),
      .opr1_i          (opr1_i),
      .busy_o          (busy_o),
      .valid_o         (valid_o),
      .quotient_o      (quotient_o),
      .remainder_o     (remainder_o),
      .div_zero_flag_o (div_zero_flag_o),
      .overflow_flag_o (overflow_flag_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   // Present a request for one edge; afterwards cyc = 1 (first cycle after E0).
   task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      start_i  = 1'b1;
      signed_i = sgn;
      opr0_i   = a;
      opr1_i   = b;
      cyc      = 0;
      tick();
      start_i  = 1'b0;
      signed_i = ~sgn;
      opr0_i   = 32'hDEAD_BEEF;
      opr1_i   = 32'h0BAD_F00D;
   endtask

   // Wait (bounded) for valid_o, check results, then check the return to idle.
   task automatic wait_result(input string tag, input logic [31:0] exp_q,
                              input logic [31:0] exp_r, input logic exp_dz,
                              input logic exp_ov, input int exp_lat);
      logic busy_gap = 1'b0;
      while (!valid_o && cyc < 60) begin
         if (!busy_o) busy_gap = 1'b1;
         tick();
      end
      check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
      check({tag, "_busy_gap"}, {31'b0, busy_gap}, 32'd0);
      check({tag, "_busy_at_valid"}, {31'b0, busy_o}, 32'd1);
      check({tag, "_quotient"}, quotient_o, exp_q);
      check({tag, "_remainder"}, remainder_o, exp_r);
      check({tag, "_div_zero"}, {31'b0, div_zero_flag_o}, {31'b0, exp_dz});
      check({tag, "_overflow"}, {31'b0, overflow_flag_o}, {31'b0, exp_ov});
      tick();
      check({tag, "_valid_drop"}, {31'b0, valid_o}, 32'd0);
      check({tag, "_busy_drop"}, {31'b0, busy_o}, 32'd0);
      check({tag, "_quotient_held"}, quotient_o, exp_q);
   endtask

   initial begin
      logic saw_valid;
      rst_i    = 1'b1;
      start_i  = 1'b0;
      signed_i = 1'b0;
      opr0_i   = '0;
      opr1_i   = '0;
      tick();
      tick();
      check("rst_busy", {31'b0, busy_o}, 32'd0);
      check("rst_valid", {31'b0, valid_o}, 32'd0);
      check("rst_quotient", quotient_o, 32'd0);
      check("rst_remainder", remainder_o, 32'd0);
      check("rst_flags", {30'b0, div_zero_flag_o, overflow_flag_o}, 32'd0);
      rst_i = 1'b0;
      tick();

      start_op(1'b0, 32'd100, 32'd7);
      wait_result("u100_7", 32'd14, 32'd2, 1'b0, 1'b0, 34);

      start_op(1'b1, 32'hFFFF_FFF9, 32'd2);
      wait_result("s_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 34);

      start_op(1'b1, 32'd7, 32'hFFFF_FFFE);
      wait_result("s_7_m2", 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, 34);

      start_op(1'b0, 32'd5, 32'd0);
      wait_result("u_div0", 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0, 1);

      start_op(1'b1, 32'd5, 32'd0);
      wait_result("s_div0", 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0, 1);

      start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_result("s_ovf", 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1);

      start_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_result("u_min_max", 32'd0, 32'h8000_0000, 1'b0, 1'b0, 34);

      start_op(1'b0, 32'hFFFF_FFFF, 32'd1);
      wait_result("u_max_1", 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 34);

      // Stray start in the middle of an operation must be ignored.
      start_op(1'b0, 32'd100, 32'd7);
      while (cyc < 9) tick();
      start_i  = 1'b1;
      signed_i = 1'b1;
      opr0_i   = 32'd9;
      opr1_i   = 32'd3;
      tick();
      start_i  = 1'b0;
      wait_result("ign_start", 32'd14, 32'd2, 1'b0, 1'b0, 34);

      // Back-to-back: wait_result leaves us in the idle cycle after valid_o.
      start_op(1'b1, 32'hFFFF_FF9C, 32'd10);
      wait_result("b2b", 32'hFFFF_FFF6, 32'd0, 1'b0, 1'b0, 34);

      // Reset mid-operation.
      start_op(1'b0, 32'd1000, 32'd33);
      while (cyc < 14) tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check("midrst_busy", {31'b0, busy_o}, 32'd0);
      check("midrst_valid", {31'b0, valid_o}, 32'd0);
      check("midrst_quotient", quotient_o, 32'd0);
      check("midrst_remainder", remainder_o, 32'd0);
      saw_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (valid_o || busy_o) saw_valid = 1'b1;
         tick();
      end
      check("midrst_no_activity", {31'b0, saw_valid}, 32'd0);

      start_op(1'b0, 32'd9, 32'd3);
      wait_result("post_rst", 32'd3, 32'd0, 1'b0, 1'b0, 34);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
